// File: rtl/gmii_pkg.sv
// gmii_pkg: shared FSM encodings, framing bytes and the CRC-32 byte-step
// function used by the GMII TX framer (and later by the RX checker).
package gmii_pkg;

   localparam logic [2:0] ST_IDLE     = 3'd0;
   localparam logic [2:0] ST_PREAMBLE = 3'd1;
   localparam logic [2:0] ST_SFD      = 3'd2;
   localparam logic [2:0] ST_DATA     = 3'd3;
   localparam logic [2:0] ST_PAD      = 3'd4;
   localparam logic [2:0] ST_FCS      = 3'd5;
   localparam logic [2:0] ST_IFG      = 3'd6;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int unsigned PREAMBLE_LEN  = 7;
   localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
   localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;

   // Reflected CRC-32: fold the byte into the low bits, then shift LSB-first.
   function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                              input logic [7:0]  data);
      logic [31:0] c;
      c = crc ^ {24'h000000, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: combinational next-CRC for one data byte (reflected 0xEDB88320).
// Shared between the TX framer and the RX FCS checker.
module crc32_d8
   import gmii_pkg::*;
(
   input  logic [31:0] crc_i,
   input  logic [7:0]  data_i,
   output logic [31:0] crc_o
);

   assign crc_o = crc32_next(crc_i, data_i);

endmodule

// File: rtl/gmii_tx_framer.sv
// gmii_tx_framer: byte stream to GMII frame (preamble, SFD, data, FCS, IFG).
// Define GMII_TX_PAD_EN to compile in zero padding of short frames to MIN_LEN.
module gmii_tx_framer
   import gmii_pkg::*;
#(
   parameter int unsigned IFG_CYCLES = 12
`ifdef GMII_TX_PAD_EN
   ,parameter int unsigned MIN_LEN   = 60
`endif
) (
   input  logic       gmii_tx_clk,
   input  logic       rst_n,
   input  logic [7:0] s_data,
   input  logic       s_valid,
   input  logic       s_last,
   output logic       s_ready,
   output logic       gmii_tx_en,
   output logic [7:0] gmii_txd,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_underrun
);

   localparam logic [7:0] IFG_LAST = 8'(IFG_CYCLES - 1);
   localparam logic [7:0] PRE_LAST = 8'(PREAMBLE_LEN - 1);

   // state_q selects what is loaded into the output registers at the next edge.
   logic [2:0]  state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] crc_q, crc_d;
   logic        bad_fcs_q, bad_fcs_d;
   logic        tx_en_q, tx_en_d;
   logic [7:0]  txd_q, txd_d;
   logic        done_q, done_d;
   logic        underrun_q, underrun_d;

   logic [31:0] crc_next;
   logic [7:0]  crc_data;
   logic [31:0] fcs_word;
   logic [7:0]  fcs_byte;

`ifdef GMII_TX_PAD_EN
   localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);

   // Byte count only matters for padding, so it exists only in that build.
   logic [10:0] byte_cnt_q, byte_cnt_d;
   logic [10:0] byte_inc;

   assign byte_inc = (byte_cnt_q == 11'h7FF) ? byte_cnt_q : byte_cnt_q + 11'd1;
   assign crc_data = (state_q == ST_PAD) ? 8'h00 : s_data;
`else
   assign crc_data = s_data;
`endif

   crc32_d8 u_crc (
      .crc_i  (crc_q),
      .data_i (crc_data),
      .crc_o  (crc_next)
   );

   assign fcs_word = bad_fcs_q ? crc_q : ~crc_q;

   always_comb begin
      case (cnt_q[1:0])
         2'd0:    fcs_byte = fcs_word[7:0];
         2'd1:    fcs_byte = fcs_word[15:8];
         2'd2:    fcs_byte = fcs_word[23:16];
         default: fcs_byte = fcs_word[31:24];
      endcase
   end

   assign s_ready     = (state_q == ST_DATA);
   assign tx_busy     = (state_q != ST_IDLE);
   assign gmii_tx_en  = tx_en_q;
   assign gmii_txd    = txd_q;
   assign tx_done     = done_q;
   assign tx_underrun = underrun_q;

   always_comb begin
      // NOTE: every signal gets a default before the case so no path infers a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      crc_d      = crc_q;
      bad_fcs_d  = bad_fcs_q;
      tx_en_d    = 1'b0;
      txd_d      = 8'h00;
      done_d     = 1'b0;
      underrun_d = 1'b0;
`ifdef GMII_TX_PAD_EN
      byte_cnt_d = byte_cnt_q;
`endif
      case (state_q)
         ST_IDLE: begin
            crc_d     = CRC32_INIT;
            bad_fcs_d = 1'b0;
            cnt_d     = '0;
`ifdef GMII_TX_PAD_EN
            byte_cnt_d = '0;
`endif
            if (s_valid) begin
               state_d = ST_PREAMBLE;
               cnt_d   = 8'd1;
               tx_en_d = 1'b1;
               txd_d   = PREAMBLE_BYTE;
            end
         end
         ST_PREAMBLE: begin
            tx_en_d = 1'b1;
            txd_d   = PREAMBLE_BYTE;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q == PRE_LAST) begin
               state_d = ST_SFD;
            end
         end
         ST_SFD: begin
            tx_en_d = 1'b1;
            txd_d   = SFD_BYTE;
            state_d = ST_DATA;
         end
         ST_DATA: begin
            tx_en_d = 1'b1;
            if (s_valid) begin
               txd_d = s_data;
               crc_d = crc_next;
`ifdef GMII_TX_PAD_EN
               byte_cnt_d = byte_inc;
`endif
               if (s_last) begin
                  cnt_d   = '0;
                  state_d = ST_FCS;
`ifdef GMII_TX_PAD_EN
                  if (byte_inc < MIN_LEN_C) begin
                     state_d = ST_PAD;
                  end
`endif
               end
            end else begin
               // Underrun: the raw register is the complement of the good FCS,
               // so the receiver is guaranteed to see a CRC error.
               underrun_d = 1'b1;
               bad_fcs_d  = 1'b1;
               txd_d      = crc_q[7:0];
               cnt_d      = 8'd1;
               state_d    = ST_FCS;
            end
         end
`ifdef GMII_TX_PAD_EN
         ST_PAD: begin
            tx_en_d    = 1'b1;
            txd_d      = 8'h00;
            crc_d      = crc_next;
            byte_cnt_d = byte_inc;
            if (byte_inc >= MIN_LEN_C) begin
               cnt_d   = '0;
               state_d = ST_FCS;
            end
         end
`endif
         ST_FCS: begin
            tx_en_d = 1'b1;
            txd_d   = fcs_byte;
            cnt_d   = cnt_q + 8'd1;
            if (cnt_q[1:0] == 2'd3) begin
               cnt_d   = '0;
               state_d = ST_IFG;
            end
         end
         ST_IFG: begin
            // First IFG cycle has the last FCS byte on the wire; done follows it.
            done_d = (cnt_q == 8'd0);
            cnt_d  = cnt_q + 8'd1;
            if (cnt_q == IFG_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         crc_q      <= CRC32_INIT;
         bad_fcs_q  <= 1'b0;
         tx_en_q    <= 1'b0;
         txd_q      <= 8'h00;
         done_q     <= 1'b0;
         underrun_q <= 1'b0;
`ifdef GMII_TX_PAD_EN
         byte_cnt_q <= '0;
`endif
      end else begin
         // NOTE: non-blocking updates so every register samples pre-edge values.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         bad_fcs_q  <= bad_fcs_d;
         tx_en_q    <= tx_en_d;
         txd_q      <= txd_d;
         done_q     <= done_d;
         underrun_q <= underrun_d;
`ifdef GMII_TX_PAD_EN
         byte_cnt_q <= byte_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb_gmii_tx_framer: scoreboard bench; the driver queues expected GMII bytes,
// a negedge monitor pops and compares every byte sent with tx_en high.
`timescale 1ns/1ps
module tb_gmii_tx_framer;

   localparam int IFG = 12;
`ifdef GMII_TX_PAD_EN
   localparam int EXP_MIN_LEN = 60;
`else
   localparam int EXP_MIN_LEN = 0;
`endif

   logic       gmii_tx_clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_last;
   logic       s_ready;
   logic       gmii_tx_en;
   logic [7:0] gmii_txd;
   logic       tx_busy;
   logic       tx_done;
   logic       tx_underrun;

   gmii_tx_framer #(.IFG_CYCLES(IFG)) dut (
      .gmii_tx_clk (gmii_tx_clk),
      .rst_n       (rst_n),
      .s_data      (s_data),
      .s_valid     (s_valid),
      .s_last      (s_last),
      .s_ready     (s_ready),
      .gmii_tx_en  (gmii_tx_en),
      .gmii_txd    (gmii_txd),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_underrun (tx_underrun)
   );

   logic [31:0] chk_crc_in;
   logic [7:0]  chk_data;
   logic [31:0] chk_crc_out;

   crc32_d8 u_crc_chk (
      .crc_i  (chk_crc_in),
      .data_i (chk_data),
      .crc_o  (chk_crc_out)
   );

   initial gmii_tx_clk = 1'b0;
   always #4 gmii_tx_clk = ~gmii_tx_clk;

   int n_checks   = 0;
   int n_failures = 0;

   logic [7:0] exp_q[$];
   logic [7:0] tx_buf [0:63];

   int   done_cnt       = 0;
   int   underrun_cnt   = 0;
   int   en_run         = 0;
   int   gap_run        = 0;
   int   last_frame_len = 0;
   int   last_gap       = 0;
   logic prev_en        = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Bit-serial LSB-first reference CRC-32.
   function automatic logic [31:0] crc_model(input logic [31:0] crc, input logic [7:0] d);
      logic [31:0] c;
      logic        fb;
      c = crc;
      for (int b = 0; b < 8; b++) begin
         fb = c[0] ^ d[b];
         c  = c >> 1;
         if (fb) c = c ^ 32'hEDB88320;
      end
      return c;
   endfunction

   // Monitor: scoreboard comparison plus frame length, gap and pulse bookkeeping.
   always @(negedge gmii_tx_clk) begin
      logic [7:0] e;
      if (!rst_n) begin
         prev_en = 1'b0;
         en_run  = 0;
         gap_run = 0;
      end else begin
         if (gmii_tx_en) begin
            if (!prev_en) begin
               last_gap = gap_run;
               en_run   = 0;
            end
            en_run++;
            if (exp_q.size() == 0) begin
               check("tx_en_unexpected", {31'd0, gmii_tx_en}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("txd", {24'd0, gmii_txd}, {24'd0, e});
            end
         end else begin
            if (prev_en) begin
               last_frame_len = en_run;
               gap_run        = 0;
            end
            if (gap_run < 100000) gap_run++;
         end
         if ((prev_en && !gmii_tx_en) || tx_done) begin
            check("tx_done_timing", {31'd0, tx_done}, {31'd0, (prev_en && !gmii_tx_en)});
         end
         if (tx_done)     done_cnt++;
         if (tx_underrun) underrun_cnt++;
         prev_en = gmii_tx_en;
      end
   end

   task automatic fill_buf(input logic [7:0] seed);
      for (int i = 0; i < 64; i++) tx_buf[i] = 8'(seed + 8'(i * 13));
   endtask

   task automatic expect_frame(input int len, input int stop_at, output int en_len);
      logic [31:0] c;
      logic [31:0] fcs;
      int          n;
      c = 32'hFFFFFFFF;
      n = 0;
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < stop_at; i++) begin
         exp_q.push_back(tx_buf[i]);
         c = crc_model(c, tx_buf[i]);
         n++;
      end
      if (stop_at == len) begin
         while (n < EXP_MIN_LEN) begin
            exp_q.push_back(8'h00);
            c = crc_model(c, 8'h00);
            n++;
         end
         fcs = ~c;
      end else begin
         fcs = (~c) ^ 32'hFFFFFFFF;
      end
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(fcs[7:0]);
         fcs = fcs >> 8;
      end
      en_len = 8 + n + 4;
   endtask

   // Offer len bytes; s_valid drops after stop_at accepted bytes.
   task automatic drive_frame(input int len, input int stop_at);
      int idx;
      int guard;
      idx     = 0;
      guard   = 0;
      s_valid = 1'b1;
      s_data  = tx_buf[0];
      s_last  = (len == 1);
      while (idx < stop_at && guard < 5000) begin
         @(negedge gmii_tx_clk);
         guard++;
         if (s_ready) begin
            @(posedge gmii_tx_clk);
            #1;
            idx++;
            if (idx < stop_at) begin
               s_data = tx_buf[idx];
               s_last = (idx == len - 1);
            end
         end
      end
      if (guard >= 5000) check("drive_stall", idx, stop_at);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic wait_done(input int target, input string name);
      int n;
      n = 0;
      while (done_cnt < target && n < 3000) begin
         @(negedge gmii_tx_clk);
         n++;
      end
      check(name, done_cnt, target);
      repeat (IFG + 4) @(negedge gmii_tx_clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int          elen;
      int          u0;
      logic [31:0] c;
      string       s;

      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 8'h00;
      repeat (3) @(posedge gmii_tx_clk);
      #1;
      check("rst_tx_en",    {31'd0, gmii_tx_en},  32'd0);
      check("rst_txd",      {24'd0, gmii_txd},    32'd0);
      check("rst_s_ready",  {31'd0, s_ready},     32'd0);
      check("rst_busy",     {31'd0, tx_busy},     32'd0);
      check("rst_done",     {31'd0, tx_done},     32'd0);
      check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
      @(posedge gmii_tx_clk);
      #2 rst_n = 1'b1;

      s = "123456789";
      c = 32'hFFFFFFFF;
      for (int i = 0; i < 9; i++) begin
         chk_crc_in = c;
         chk_data   = s[i];
         #1;
         c = chk_crc_out;
      end
      check("crc32_d8_check", ~c, 32'hCBF43926);

      repeat (2) @(posedge gmii_tx_clk);
      #1;
      check("idle_no_valid", {31'd0, tx_busy}, 32'd0);

      // 64-byte frame, s_valid held.
      fill_buf(8'h01);
      expect_frame(64, 64, elen);
      drive_frame(64, 64);
      wait_done(1, "done_64");
      check("len_64", last_frame_len, elen);
      check("drain_64", exp_q.size(), 0);

      // 20-byte frame: padded to 60 only when padding is compiled in.
      fill_buf(8'h40);
      expect_frame(20, 20, elen);
      drive_frame(20, 20);
      wait_done(2, "done_20");
      check("len_20", last_frame_len, elen);
      check("drain_20", exp_q.size(), 0);

      // Back-to-back: s_valid stays high through the IFG.
      fill_buf(8'h80);
      expect_frame(64, 64, elen);
      drive_frame(64, 64);
      fill_buf(8'hC3);
      expect_frame(64, 64, elen);
      drive_frame(64, 64);
      wait_done(4, "done_b2b");
      check("b2b_gap", last_gap, IFG);
      check("len_b2b", last_frame_len, elen);
      check("drain_b2b", exp_q.size(), 0);

      // Underrun after 30 bytes.
      fill_buf(8'h11);
      u0 = underrun_cnt;
      expect_frame(64, 30, elen);
      drive_frame(64, 30);
      wait_done(5, "done_underrun");
      check("underrun_pulses", underrun_cnt - u0, 1);
      check("len_underrun", last_frame_len, elen);
      check("drain_underrun", exp_q.size(), 0);
      check("idle_after_underrun", {31'd0, tx_busy}, 32'd0);

      // Reset asserted mid-DATA.
      for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
      exp_q.push_back(8'hD5);
      for (int i = 0; i < 40; i++) exp_q.push_back(8'hA5);
      s_data  = 8'hA5;
      s_last  = 1'b0;
      s_valid = 1'b1;
      repeat (20) @(posedge gmii_tx_clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_tx_en", {31'd0, gmii_tx_en}, 32'd0);
      check("rst_mid_busy",  {31'd0, tx_busy},    32'd0);
      s_valid = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge gmii_tx_clk);
      #2 rst_n = 1'b1;
      repeat (10) @(negedge gmii_tx_clk);
      check("idle_after_reset_en",   {31'd0, gmii_tx_en}, 32'd0);
      check("idle_after_reset_busy", {31'd0, tx_busy},    32'd0);

      // Clean frame after reset.
      fill_buf(8'h5A);
      expect_frame(20, 20, elen);
      drive_frame(20, 20);
      wait_done(6, "done_after_reset");
      check("len_after_reset", last_frame_len, elen);
      check("drain_after_reset", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_failures);
      $finish;
   end

endmodule
